// File: rtl/rf_write_ctrl.sv
// rtl/rf_write_ctrl.sv - windowed register-file write decode with CWP/WIM window control
// Write enables are registered one cycle; decode always uses the pre-edge CWP.
module rf_write_ctrl #(
  parameter int NWINDOWS = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                WrEn,
  input  logic [4:0]          RD,
  input  logic [31:0]         WrData,
  input  logic                Save,
  input  logic                Restore,
  input  logic                CwpWe,
  input  logic [2:0]          CwpIn,
  input  logic                WimWe,
  input  logic [NWINDOWS-1:0] WimIn,
  output logic                BE,
  output logic [7:0]          RE,
  output logic [NWINDOWS-1:0] WinBE,
  output logic [15:0]         WinRE,
  output logic [31:0]         DataOut,
  output logic [2:0]          CWP,
  output logic [NWINDOWS-1:0] WIM,
  output logic                WinOverflow,
  output logic                WinUnderflow
);

  logic                be_q, be_d;
  logic [7:0]          re_q, re_d;
  logic [NWINDOWS-1:0] winbe_q, winbe_d;
  logic [15:0]         winre_q, winre_d;
  logic [31:0]         data_q, data_d;
  logic [2:0]          cwp_q, cwp_d;
  logic [NWINDOWS-1:0] wim_q, wim_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  logic [2:0] cwp_m1, cwp_p1, cwp_in_mod;
  logic       wim_m1, wim_p1;

  assign cwp_m1     = (cwp_q == 3'd0) ? 3'(NWINDOWS - 1) : cwp_q - 3'd1;
  assign cwp_p1     = (cwp_q == 3'(NWINDOWS - 1)) ? 3'd0 : cwp_q + 3'd1;
  assign cwp_in_mod = 3'(32'(CwpIn) % NWINDOWS);
  // Trap checks look at the WIM held before this edge, even if WimWe rewrites it now.
  assign wim_m1     = |(wim_q & (NWINDOWS'(1) << cwp_m1));
  assign wim_p1     = |(wim_q & (NWINDOWS'(1) << cwp_p1));

  always_comb begin
    be_d    = 1'b0;
    re_d    = 8'd0;
    winbe_d = '0;
    winre_d = 16'd0;
    data_d  = data_q;
    cwp_d   = cwp_q;
    wim_d   = wim_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;

    if (WrEn) begin
      data_d = WrData;
      case (RD[4:3])
        2'b00: begin
          if (RD[2:0] != 3'd0) begin
            be_d = 1'b1;
            re_d = 8'd1 << RD[2:0];
          end
        end
        // Outs of this window are the ins of the window at CWP-1.
        2'b01: begin
          winbe_d = NWINDOWS'(1) << cwp_m1;
          winre_d = 16'd1 << RD[3:0];
        end
        default: begin
          winbe_d = NWINDOWS'(1) << cwp_q;
          winre_d = 16'd1 << RD[3:0];
        end
      endcase
    end

    if (WimWe) wim_d = WimIn;

    if (CwpWe) begin
      cwp_d = cwp_in_mod;
    end else if (Save && !Restore) begin
      if (wim_m1) ovf_d = 1'b1;
      else        cwp_d = cwp_m1;
    end else if (Restore && !Save) begin
      if (wim_p1) unf_d = 1'b1;
      else        cwp_d = cwp_p1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      be_q    <= 1'b0;
      re_q    <= 8'd0;
      winbe_q <= '0;
      winre_q <= 16'd0;
      data_q  <= 32'd0;
      cwp_q   <= 3'd0;
      wim_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      be_q    <= be_d;
      re_q    <= re_d;
      winbe_q <= winbe_d;
      winre_q <= winre_d;
      data_q  <= data_d;
      cwp_q   <= cwp_d;
      wim_q   <= wim_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign BE           = be_q;
  assign RE           = re_q;
  assign WinBE        = winbe_q;
  assign WinRE        = winre_q;
  assign DataOut      = data_q;
  assign CWP          = cwp_q;
  assign WIM          = wim_q;
  assign WinOverflow  = ovf_q;
  assign WinUnderflow = unf_q;

endmodule

// File: tb/tb_rf_write_ctrl.sv
// tb/tb_rf_write_ctrl.sv - directed scoreboard bench for rf_write_ctrl with NWINDOWS=4
module tb_rf_write_ctrl;
  localparam int NW = 4;

  logic          Clk = 1'b0;
  logic          Reset, WrEn, Save, Restore, CwpWe, WimWe;
  logic [4:0]    RD;
  logic [31:0]   WrData;
  logic [2:0]    CwpIn;
  logic [NW-1:0] WimIn;
  logic          BE, WinOverflow, WinUnderflow;
  logic [7:0]    RE;
  logic [NW-1:0] WinBE, WIM;
  logic [15:0]   WinRE;
  logic [31:0]   DataOut;
  logic [2:0]    CWP;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic          be;
    logic [7:0]    re;
    logic [NW-1:0] winbe;
    logic [15:0]   winre;
    logic [31:0]   data;
    logic [2:0]    cwp;
    logic [NW-1:0] wim;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  rf_write_ctrl #(.NWINDOWS(NW)) dut (
    .Clk(Clk), .Reset(Reset), .WrEn(WrEn), .RD(RD), .WrData(WrData),
    .Save(Save), .Restore(Restore), .CwpWe(CwpWe), .CwpIn(CwpIn),
    .WimWe(WimWe), .WimIn(WimIn), .BE(BE), .RE(RE), .WinBE(WinBE),
    .WinRE(WinRE), .DataOut(DataOut), .CWP(CWP), .WIM(WIM),
    .WinOverflow(WinOverflow), .WinUnderflow(WinUnderflow)
  );

  always #5 Clk = ~Clk;

  task automatic idle();
    Reset = 1'b0; WrEn = 1'b0; RD = 5'd0; WrData = 32'd0;
    Save = 1'b0; Restore = 1'b0; CwpWe = 1'b0; CwpIn = 3'd0;
    WimWe = 1'b0; WimIn = '0;
  endtask

  task automatic expect_out(input string tag, input logic be, input logic [7:0] re,
                            input logic [NW-1:0] winbe, input logic [15:0] winre,
                            input logic [31:0] data, input logic [2:0] cwp,
                            input logic [NW-1:0] wim, input logic ovf, input logic unf);
    exp_t e;
    e.be = be; e.re = re; e.winbe = winbe; e.winre = winre; e.data = data;
    e.cwp = cwp; e.wim = wim; e.ovf = ovf; e.unf = unf;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic chk(input string tag, input string fld, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
    end
  endtask

  task automatic cycle_check();
    exp_t  e;
    string t;
    @(posedge Clk);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      chk(t, "BE",    32'(BE),           32'(e.be));
      chk(t, "RE",    32'(RE),           32'(e.re));
      chk(t, "WinBE", 32'(WinBE),        32'(e.winbe));
      chk(t, "WinRE", 32'(WinRE),        32'(e.winre));
      chk(t, "Data",  DataOut,           e.data);
      chk(t, "CWP",   32'(CWP),          32'(e.cwp));
      chk(t, "WIM",   32'(WIM),          32'(e.wim));
      chk(t, "Ovf",   32'(WinOverflow),  32'(e.ovf));
      chk(t, "Unf",   32'(WinUnderflow), 32'(e.unf));
    end
  endtask

  initial begin
    idle();
    // Reset dominates a simultaneous write request.
    Reset = 1'b1; WrEn = 1'b1; RD = 5'd5; WrData = 32'h1234_5678;
    expect_out("reset", 0, 8'h00, 4'b0000, 16'h0000, 32'h0, 3'd0, 4'b0000, 0, 0);
    cycle_check();

    idle(); WrEn = 1'b1; RD = 5'd5; WrData = 32'hDEAD_BEEF;
    expect_out("g5", 1, 8'h20, 4'b0000, 16'h0000, 32'hDEAD_BEEF, 3'd0, 4'b0000, 0, 0);
    cycle_check();

    idle();
    expect_out("idle_hold", 0, 8'h00, 4'b0000, 16'h0000, 32'hDEAD_BEEF, 3'd0, 4'b0000, 0, 0);
    cycle_check();

    idle(); WrEn = 1'b1; RD = 5'd10; WrData = 32'h1;
    expect_out("o10_cwp0", 0, 8'h00, 4'b1000, 16'h0400, 32'h1, 3'd0, 4'b0000, 0, 0);
    cycle_check();

    idle(); WrEn = 1'b1; RD = 5'd26; WrData = 32'h2;
    expect_out("i26_cwp0", 0, 8'h00, 4'b0001, 16'h0400, 32'h2, 3'd0, 4'b0000, 0, 0);
    cycle_check();

    idle(); WrEn = 1'b1; RD = 5'd31; WrData = 32'h3;
    expect_out("i31_cwp0", 0, 8'h00, 4'b0001, 16'h8000, 32'h3, 3'd0, 4'b0000, 0, 0);
    cycle_check();

    idle(); WrEn = 1'b1; RD = 5'd8; WrData = 32'h4;
    expect_out("o8_cwp0", 0, 8'h00, 4'b1000, 16'h0100, 32'h4, 3'd0, 4'b0000, 0, 0);
    cycle_check();

    idle(); WrEn = 1'b1; RD = 5'd7; WrData = 32'h5;
    expect_out("g7", 1, 8'h80, 4'b0000, 16'h0000, 32'h5, 3'd0, 4'b0000, 0, 0);
    cycle_check();

    // Write in the Save cycle still decodes against CWP=0.
    idle(); Save = 1'b1; WrEn = 1'b1; RD = 5'd10; WrData = 32'h6;
    expect_out("save_wr", 0, 8'h00, 4'b1000, 16'h0400, 32'h6, 3'd3, 4'b0000, 0, 0);
    cycle_check();

    idle(); WrEn = 1'b1; RD = 5'd20; WrData = 32'h7;
    expect_out("l20_cwp3", 0, 8'h00, 4'b1000, 16'h0010, 32'h7, 3'd3, 4'b0000, 0, 0);
    cycle_check();

    idle(); WrEn = 1'b1; RD = 5'd12; WrData = 32'h8;
    expect_out("o12_cwp3", 0, 8'h00, 4'b0100, 16'h1000, 32'h8, 3'd3, 4'b0000, 0, 0);
    cycle_check();

    idle(); Restore = 1'b1;
    expect_out("restore_wrap", 0, 8'h00, 4'b0000, 16'h0000, 32'h8, 3'd0, 4'b0000, 0, 0);
    cycle_check();

    idle(); WimWe = 1'b1; WimIn = 4'b0010;
    expect_out("wim_load", 0, 8'h00, 4'b0000, 16'h0000, 32'h8, 3'd0, 4'b0010, 0, 0);
    cycle_check();

    idle(); Restore = 1'b1;
    expect_out("underflow", 0, 8'h00, 4'b0000, 16'h0000, 32'h8, 3'd0, 4'b0010, 0, 1);
    cycle_check();

    idle();
    expect_out("unf_pulse_end", 0, 8'h00, 4'b0000, 16'h0000, 32'h8, 3'd0, 4'b0010, 0, 0);
    cycle_check();

    idle(); Save = 1'b1;
    expect_out("save_ok", 0, 8'h00, 4'b0000, 16'h0000, 32'h8, 3'd3, 4'b0010, 0, 0);
    cycle_check();

    idle(); CwpWe = 1'b1; CwpIn = 3'd2;
    expect_out("cwp_load2", 0, 8'h00, 4'b0000, 16'h0000, 32'h8, 3'd2, 4'b0010, 0, 0);
    cycle_check();

    // Trapped Save: CWP holds, overflow pulses, write completes.
    idle(); Save = 1'b1; WrEn = 1'b1; RD = 5'd17; WrData = 32'h9;
    expect_out("overflow_wr", 0, 8'h00, 4'b0100, 16'h0002, 32'h9, 3'd2, 4'b0010, 1, 0);
    cycle_check();

    idle();
    expect_out("ovf_pulse_end", 0, 8'h00, 4'b0000, 16'h0000, 32'h9, 3'd2, 4'b0010, 0, 0);
    cycle_check();

    idle(); Save = 1'b1; Restore = 1'b1;
    expect_out("save_restore", 0, 8'h00, 4'b0000, 16'h0000, 32'h9, 3'd2, 4'b0010, 0, 0);
    cycle_check();

    idle(); CwpWe = 1'b1; CwpIn = 3'd4; Save = 1'b1;
    expect_out("cwpwe_masks_trap", 0, 8'h00, 4'b0000, 16'h0000, 32'h9, 3'd0, 4'b0010, 0, 0);
    cycle_check();

    idle(); CwpWe = 1'b1; CwpIn = 3'd6;
    expect_out("cwp_in6_mod", 0, 8'h00, 4'b0000, 16'h0000, 32'h9, 3'd2, 4'b0010, 0, 0);
    cycle_check();

    idle(); WimWe = 1'b1; WimIn = 4'b0000; Save = 1'b1;
    expect_out("save_old_wim", 0, 8'h00, 4'b0000, 16'h0000, 32'h9, 3'd2, 4'b0000, 1, 0);
    cycle_check();

    idle(); WrEn = 1'b1; RD = 5'd0; WrData = 32'h0000_00A5;
    expect_out("rd0_noop", 0, 8'h00, 4'b0000, 16'h0000, 32'h0000_00A5, 3'd2, 4'b0000, 0, 0);
    cycle_check();

    idle(); WrEn = 1'b1; RD = 5'd3; WrData = 32'h0000_0055; WimWe = 1'b1; WimIn = 4'b0101;
    expect_out("g3", 1, 8'h08, 4'b0000, 16'h0000, 32'h0000_0055, 3'd2, 4'b0101, 0, 0);
    cycle_check();

    idle(); Reset = 1'b1;
    expect_out("reset_after_wr", 0, 8'h00, 4'b0000, 16'h0000, 32'h0, 3'd0, 4'b0000, 0, 0);
    cycle_check();

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
